pipe_reg_de_ctrl: RTL and testbench

//  Parametrised Decode->Execute pipeline register with stall, flush and valid tracking.

---
 rtl/pipe_reg_de_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_reg_de_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_de_ctrl.sv
// Decode->Execute pipeline register.
// Carries the datapath, control and hazard fields from the register-file stage
// to the ALU stage. It supports stall (hold), flush (bubble) and valid tracking,
// and keeps saturating stall/flush event counters for performance debug.
module pipe_reg_de_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  ValidD,
    input  logic [CTRL_WIDTH-1:0] CtrlD,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] ImmExtD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [ADDR_WIDTH-1:0] Rs1D,
    input  logic [ADDR_WIDTH-1:0] Rs2D,
    input  logic [ADDR_WIDTH-1:0] RdD,
    output logic                  ValidE,
    output logic [CTRL_WIDTH-1:0] CtrlE,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] ImmExtE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [ADDR_WIDTH-1:0] Rs1E,
    output logic [ADDR_WIDTH-1:0] Rs2E,
    output logic [ADDR_WIDTH-1:0] RdE,
    output logic [CNT_WIDTH-1:0]  StallCount,
    output logic [CNT_WIDTH-1:0]  FlushCount
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Pipeline register: reset > flush (bubble) > stall (hold) > load from D.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ValidE   <= 1'b0;
            CtrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            ImmExtE  <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (FlushE) begin
            // Bubble: nothing downstream may forward from or write back this slot.
            ValidE   <= 1'b0;
            CtrlE    <= '0;
            RD1E     <= '0;
            RD2E     <= '0;
            PCE      <= '0;
            ImmExtE  <= '0;
            PCPlus4E <= '0;
            Rs1E     <= '0;
            Rs2E     <= '0;
            RdE      <= '0;
        end else if (!StallE) begin
            // An invalid slot carries no control and no destination, so it can
            // never write state or look like a forwarding source.
            ValidE   <= ValidD;
            CtrlE    <= ValidD ? CtrlD : '0;
            RD1E     <= RD1D;
            RD2E     <= RD2D;
            PCE      <= PCD;
            ImmExtE  <= ImmExtD;
            PCPlus4E <= PCPlus4D;
            Rs1E     <= Rs1D;
            Rs2E     <= Rs2D;
            RdE      <= ValidD ? RdD : '0;
        end
        // NOTE: with StallE=1 no branch assigns, so the flops simply keep their
        // value; inside always_ff that is a hold, not an inferred latch.
    end

    // Event counters: a flush edge counts as a flush only, never as a stall.
    // Both saturate at all-ones and are cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else if (FlushE) begin
            if (FlushCount != CNT_MAX) begin
                FlushCount <= FlushCount + CNT_ONE;
            end
        end else if (StallE) begin
            if (StallCount != CNT_MAX) begin
                StallCount <= StallCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipe_reg_de_ctrl.sv
// Self-checking bench for pipe_reg_de_ctrl.
// Two instances share all inputs: one with default counter width, one with a
// 4-bit counter so saturation is reachable quickly. A behavioural model of the
// E stage is compared against both on every falling edge; directed steps add
// hand-computed literal expectations.
module tb_pipe_reg_de_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          StallE, FlushE, ValidD;
    logic [CW-1:0] CtrlD;
    logic [DW-1:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
    logic [AW-1:0] Rs1D, Rs2D, RdD;

    // Default-width instance outputs
    logic          ValidE;
    logic [CW-1:0] CtrlE;
    logic [DW-1:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [AW-1:0] Rs1E, Rs2E, RdE;
    logic [15:0]   StallCount, FlushCount;

    // 4-bit-counter instance outputs
    logic          s_ValidE;
    logic [CW-1:0] s_CtrlE;
    logic [DW-1:0] s_RD1E, s_RD2E, s_PCE, s_ImmExtE, s_PCPlus4E;
    logic [AW-1:0] s_Rs1E, s_Rs2E, s_RdE;
    logic [3:0]    s_StallCount, s_FlushCount;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    pipe_reg_de_ctrl dut (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
        .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(ValidE), .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
        .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .StallCount(StallCount), .FlushCount(FlushCount)
    );

    pipe_reg_de_ctrl #(.CNT_WIDTH(4)) dut_sat (
        .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
        .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ValidE(s_ValidE), .CtrlE(s_CtrlE), .RD1E(s_RD1E), .RD2E(s_RD2E),
        .PCE(s_PCE), .ImmExtE(s_ImmExtE), .PCPlus4E(s_PCPlus4E), .Rs1E(s_Rs1E),
        .Rs2E(s_Rs2E), .RdE(s_RdE), .StallCount(s_StallCount),
        .FlushCount(s_FlushCount)
    );

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          valid;
        bit [CW-1:0] ctrl;
        bit [DW-1:0] rd1, rd2, pc, imm, pc4;
        bit [AW-1:0] rs1, rs2, rd;
    } stage_t;

    stage_t m_e;
    int     m_sc16 = 0, m_fc16 = 0, m_sc4 = 0, m_fc4 = 0;

    function automatic stage_t empty_stage();
        stage_t s;
        s.valid = 0; s.ctrl = '0; s.rd1 = '0; s.rd2 = '0; s.pc = '0;
        s.imm = '0; s.pc4 = '0; s.rs1 = '0; s.rs2 = '0; s.rd = '0;
        return s;
    endfunction

    function automatic int bump(int v, int limit);
        return (v + 1 > limit) ? limit : v + 1;
    endfunction

    initial m_e = empty_stage();

    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_e = empty_stage();
            m_sc16 = 0; m_fc16 = 0; m_sc4 = 0; m_fc4 = 0;
        end else if (FlushE) begin
            m_e = empty_stage();
            m_fc16 = bump(m_fc16, 65535);
            m_fc4  = bump(m_fc4, 15);
        end else if (StallE) begin
            m_sc16 = bump(m_sc16, 65535);
            m_sc4  = bump(m_sc4, 15);
        end else begin
            m_e.valid = ValidD;
            m_e.ctrl  = ValidD ? CtrlD : '0;
            m_e.rd    = ValidD ? RdD : '0;
            m_e.rd1 = RD1D; m_e.rd2 = RD2D; m_e.pc = PCD;
            m_e.imm = ImmExtD; m_e.pc4 = PCPlus4D;
            m_e.rs1 = Rs1D; m_e.rs2 = Rs2D;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model comparison on every falling edge once reset has been applied.
    always @(negedge clk) begin
        if (check_en) begin
            check("ValidE", 64'(ValidE), 64'(m_e.valid));
            check("CtrlE", 64'(CtrlE), 64'(m_e.ctrl));
            check("RD1E", 64'(RD1E), 64'(m_e.rd1));
            check("RD2E", 64'(RD2E), 64'(m_e.rd2));
            check("PCE", 64'(PCE), 64'(m_e.pc));
            check("ImmExtE", 64'(ImmExtE), 64'(m_e.imm));
            check("PCPlus4E", 64'(PCPlus4E), 64'(m_e.pc4));
            check("Rs1E", 64'(Rs1E), 64'(m_e.rs1));
            check("Rs2E", 64'(Rs2E), 64'(m_e.rs2));
            check("RdE", 64'(RdE), 64'(m_e.rd));
            check("StallCount", 64'(StallCount), 64'(m_sc16));
            check("FlushCount", 64'(FlushCount), 64'(m_fc16));
            check("sat.ValidE", 64'(s_ValidE), 64'(m_e.valid));
            check("sat.CtrlE", 64'(s_CtrlE), 64'(m_e.ctrl));
            check("sat.RD1E", 64'(s_RD1E), 64'(m_e.rd1));
            check("sat.RdE", 64'(s_RdE), 64'(m_e.rd));
            check("sat.StallCount", 64'(s_StallCount), 64'(m_sc4));
            check("sat.FlushCount", 64'(s_FlushCount), 64'(m_fc4));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] r1,
                         input logic [DW-1:0] r2, input logic [DW-1:0] pc,
                         input logic [DW-1:0] imm, input logic [AW-1:0] s1,
                         input logic [AW-1:0] s2, input logic [AW-1:0] d);
        ValidD = v; CtrlD = c; RD1D = r1; RD2D = r2; PCD = pc;
        ImmExtD = imm; PCPlus4D = pc + 32'd4; Rs1D = s1; Rs2D = s2; RdD = d;
    endtask

    initial begin
        // 1. Reset with random D inputs for two edges.
        rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
        set_d(1'b1, 12'($urandom), $urandom, $urandom, $urandom, $urandom,
              5'($urandom), 5'($urandom), 5'($urandom));
        tick();
        check_en = 1'b1;
        set_d(1'b1, 12'($urandom), $urandom, $urandom, $urandom, $urandom,
              5'($urandom), 5'($urandom), 5'($urandom));
        tick();
        check("rst ValidE", 64'(ValidE), 64'd0);
        check("rst RD1E", 64'(RD1E), 64'd0);
        check("rst CtrlE", 64'(CtrlE), 64'd0);
        check("rst StallCount", 64'(StallCount), 64'd0);

        // 2. Plain load, one-cycle latency.
        rst = 1'b0;
        set_d(1'b1, 12'hABC, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_1000,
              32'hFFFF_FFF0, 5'd1, 5'd2, 5'd7);
        tick();
        check("load RD1E", 64'(RD1E), 64'hDEAD_BEEF);
        check("load RdE", 64'(RdE), 64'd7);
        check("load CtrlE", 64'(CtrlE), 64'hABC);
        check("load ValidE", 64'(ValidE), 64'd1);
        check("load PCPlus4E", 64'(PCPlus4E), 64'h0000_1004);

        // 3. Stall for three edges with changing D values.
        StallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_d(1'b1, 12'h100 + 12'(i), 32'hCAFE_0000 + 32'(i), 32'(i), 32'h2000,
                  32'h0, 5'd10, 5'd11, 5'd12 + 5'(i));
            tick();
        end
        check("stall RD1E held", 64'(RD1E), 64'hDEAD_BEEF);
        check("stall RdE held", 64'(RdE), 64'd7);
        check("stall CtrlE held", 64'(CtrlE), 64'hABC);
        check("stall StallCount", 64'(StallCount), 64'd3);
        check("stall FlushCount", 64'(FlushCount), 64'd0);
        StallE = 1'b0;
        set_d(1'b1, 12'h321, 32'h0BAD_F00D, 32'h5, 32'h3000, 32'h8, 5'd3, 5'd4, 5'd9);
        tick();
        check("release RD1E", 64'(RD1E), 64'h0BAD_F00D);
        check("release RdE", 64'(RdE), 64'd9);

        // 4. Flush and stall on the same edge: flush wins, stall not counted.
        StallE = 1'b1; FlushE = 1'b1;
        tick();
        check("flush ValidE", 64'(ValidE), 64'd0);
        check("flush CtrlE", 64'(CtrlE), 64'd0);
        check("flush RdE", 64'(RdE), 64'd0);
        check("flush RD1E", 64'(RD1E), 64'd0);
        check("flush FlushCount", 64'(FlushCount), 64'd1);
        check("flush StallCount", 64'(StallCount), 64'd3);
        StallE = 1'b0; FlushE = 1'b0;

        // 5. Invalid slot: control and destination suppressed, rest loads.
        set_d(1'b0, 12'hFFF, 32'h7777_7777, 32'h1, 32'h4000, 32'h2, 5'd9, 5'd8, 5'd3);
        tick();
        check("inv CtrlE", 64'(CtrlE), 64'd0);
        check("inv RdE", 64'(RdE), 64'd0);
        check("inv ValidE", 64'(ValidE), 64'd0);
        check("inv Rs1E", 64'(Rs1E), 64'd9);
        check("inv RD1E", 64'(RD1E), 64'h7777_7777);

        // Mixed directed vectors: {stall, flush, valid}
        for (int i = 0; i < 8; i++) begin
            StallE = (i % 3) == 1;
            FlushE = (i == 5);
            set_d(i[0], 12'h0F0 ^ 12'(i), 32'h1000_0000 * 32'(i), 32'(i * 3),
                  32'h100 * 32'(i), 32'(i), 5'(i), 5'(i + 1), 5'(31 - i));
            tick();
        end
        StallE = 1'b0; FlushE = 1'b0;

        // 6. Saturation: 4-bit stall counter stops at F, wide one keeps counting.
        // Stalls so far: 3 (test 3) + 3 (loop i=1,4,7) = 6.
        StallE = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("sat StallCount", 64'(s_StallCount), 64'hF);
        check("wide StallCount", 64'(StallCount), 64'd26);
        StallE = 1'b0; FlushE = 1'b1;
        for (int i = 0; i < 18; i++) tick();
        check("sat FlushCount", 64'(s_FlushCount), 64'hF);
        check("wide FlushCount", 64'(FlushCount), 64'd20);

        // Reset mid-stall and mid-flush clears everything.
        rst = 1'b1; StallE = 1'b1; FlushE = 1'b1;
        tick();
        check("rst2 sat StallCount", 64'(s_StallCount), 64'd0);
        check("rst2 StallCount", 64'(StallCount), 64'd0);
        check("rst2 FlushCount", 64'(FlushCount), 64'd0);
        check("rst2 ValidE", 64'(ValidE), 64'd0);
        rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;
        set_d(1'b1, 12'h055, 32'hA5A5_A5A5, 32'h0, 32'h10, 32'h0, 5'd5, 5'd6, 5'd31);
        tick();
        check("post-rst RdE", 64'(RdE), 64'd31);
        check("post-rst CtrlE", 64'(CtrlE), 64'h055);
        tick();

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
